// File: rtl/pll_reconfig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_pkg
// Brief    : Shared register map, FSM states, and counter-word helpers for
//            the PLL reconfiguration sequencer.
// Revision : 1.0
// ============================================================================
package pll_reconfig_pkg;

    localparam logic [7:0] c_addr_mode   = 8'h00;
    localparam logic [7:0] c_addr_status = 8'h01;
    localparam logic [7:0] c_addr_start  = 8'h02;
    localparam logic [7:0] c_addr_n      = 8'h03;
    localparam logic [7:0] c_addr_m      = 8'h04;
    localparam logic [7:0] c_addr_c      = 8'h05;

    typedef enum logic [3:0] {
        ST_LOCK_WAIT,
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_C0,
        ST_WR_START,
        ST_POLL,
        ST_LOCK_WAIT_REQ
    } state_t;

    // Counter word layout: [17] odd, [16] bypass, [15:8] hi, [7:0] lo
    function automatic logic [17:0] pack_word(input logic [7:0] hi,
                                              input logic [7:0] lo,
                                              input logic       bypass,
                                              input logic       odd);
        return {odd, bypass, hi, lo};
    endfunction

    // 65 MHz outclk_0 from the 50 MHz reference
    localparam logic [17:0] c_preset_65m_n  = 18'h00101;
    localparam logic [17:0] c_preset_65m_m  = 18'h20706;
    localparam logic [17:0] c_preset_65m_c0 = 18'h20302;

endpackage
`default_nettype wire

// File: rtl/pll_reconfig_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_sequencer_if
// Brief    : Avalon-MM management port of the PLL reconfiguration core.
// Revision : 1.0
// ============================================================================
interface pll_reconfig_sequencer_if #(
    parameter int ADDR_W = 6
) ();

    logic [ADDR_W-1:0] mgmt_address;
    logic              mgmt_write;
    logic              mgmt_read;
    logic [31:0]       mgmt_writedata;
    logic [31:0]       mgmt_readdata;
    logic              mgmt_waitrequest;

    modport master (
        output mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
        input  mgmt_readdata, mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
        output mgmt_readdata, mgmt_waitrequest
    );

endinterface
`default_nettype wire

// File: rtl/pll_lock_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_debounce
// Brief    : Counts consecutive locked cycles; o_stable flags the cycle on
//            which the count reaches LOCK_STABLE.
// Revision : 1.0
// ============================================================================
module pll_lock_debounce #(
    parameter int LOCK_STABLE = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_locked,
    output logic o_stable
);

    localparam int c_cnt_w = $clog2(LOCK_STABLE + 1);

    logic [c_cnt_w-1:0] r_cnt_q;
    logic [c_cnt_w-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (!i_en || i_clr || !i_locked) begin
            w_cnt_d = '0;
        end else if (int'(r_cnt_q) < LOCK_STABLE) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Asserted on the edge that would take the count to LOCK_STABLE
    assign o_stable = i_en && i_locked && (int'(r_cnt_q) >= LOCK_STABLE - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_sequencer
// Brief    : Programs N/M/C0 through the PLL reconfig management port, then
//            waits for stable lock before releasing pll_ready.
// Revision : 1.0
// ============================================================================
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int LOCK_STABLE    = 1024,
    parameter int ADDR_W         = 6
) (
    input  logic                     refclk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [17:0]              req_n,
    input  logic [17:0]              req_m,
    input  logic [17:0]              req_c0,
    pll_reconfig_sequencer_if.master mgmt,
    input  logic                     pll_locked,
    output logic                     pll_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);

    state_t              r_state_q, w_state_d;
    logic [17:0]         r_n_q, w_n_d;
    logic [17:0]         r_m_q, w_m_d;
    logic [17:0]         r_c0_q, w_c0_d;
    logic [ADDR_W-1:0]   r_addr_q, w_addr_d;
    logic                r_write_q, w_write_d;
    logic                r_read_q, w_read_d;
    logic [31:0]         r_wdata_q, w_wdata_d;
    logic                r_done_q, w_done_d;
    logic                r_error_q, w_error_d;
    logic                r_pll_ready_q, w_pll_ready_d;
    logic [c_tmo_w-1:0]  r_tmo_q, w_tmo_d;

    logic w_lock_en;
    logic w_lock_stable;
    logic w_tmo_active;
    logic w_tmo_expired;
    logic w_xfer_ok;
    logic w_unused_rdata;

    assign w_lock_en     = (r_state_q == ST_LOCK_WAIT) || (r_state_q == ST_LOCK_WAIT_REQ);
    assign w_tmo_active  = r_state_q inside {ST_WR_START, ST_POLL, ST_LOCK_WAIT_REQ};
    assign w_tmo_expired = w_tmo_active && (int'(r_tmo_q) >= TIMEOUT_CYCLES - 1);
    assign w_xfer_ok     = !mgmt.mgmt_waitrequest;
    assign w_unused_rdata = ^mgmt.mgmt_readdata[31:1];

    pll_lock_debounce #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_debounce (
        .clk      (refclk),
        .rst      (rst),
        .i_en     (w_lock_en),
        .i_clr    (w_tmo_expired),
        .i_locked (pll_locked),
        .o_stable (w_lock_stable)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_n_d         = r_n_q;
        w_m_d         = r_m_q;
        w_c0_d        = r_c0_q;
        w_addr_d      = r_addr_q;
        w_write_d     = r_write_q;
        w_read_d      = r_read_q;
        w_wdata_d     = r_wdata_q;
        w_done_d      = 1'b0;
        w_error_d     = r_error_q;
        w_pll_ready_d = r_pll_ready_q;

        w_tmo_d = r_tmo_q;
        if (!w_tmo_active) begin
            w_tmo_d = '0;
        end else if (int'(r_tmo_q) < TIMEOUT_CYCLES) begin
            w_tmo_d = r_tmo_q + 1'b1;
        end

        // Strobes are loaded on the same edge as the state they belong to
        case (r_state_q)
            ST_LOCK_WAIT: begin
                if (w_lock_stable) begin
                    w_state_d     = ST_IDLE;
                    w_pll_ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    w_n_d         = req_n;
                    w_m_d         = req_m;
                    w_c0_d        = req_c0;
                    w_error_d     = 1'b0;
                    w_pll_ready_d = 1'b0;
                    w_state_d     = ST_WR_MODE;
                    w_write_d     = 1'b1;
                    w_addr_d      = ADDR_W'(c_addr_mode);
                    w_wdata_d     = 32'd1;
                end else if (!pll_locked) begin
                    w_pll_ready_d = 1'b0;
                    w_state_d     = ST_LOCK_WAIT;
                end
            end
            ST_WR_MODE: begin
                if (w_xfer_ok) begin
                    w_state_d = ST_WR_N;
                    w_addr_d  = ADDR_W'(c_addr_n);
                    w_wdata_d = {14'b0, r_n_q};
                end
            end
            ST_WR_N: begin
                if (w_xfer_ok) begin
                    w_state_d = ST_WR_M;
                    w_addr_d  = ADDR_W'(c_addr_m);
                    w_wdata_d = {14'b0, r_m_q};
                end
            end
            ST_WR_M: begin
                if (w_xfer_ok) begin
                    w_state_d = ST_WR_C0;
                    w_addr_d  = ADDR_W'(c_addr_c);
                    w_wdata_d = {9'b0, 5'd0, r_c0_q};
                end
            end
            ST_WR_C0: begin
                if (w_xfer_ok) begin
                    w_state_d = ST_WR_START;
                    w_addr_d  = ADDR_W'(c_addr_start);
                    w_wdata_d = 32'd1;
                end
            end
            ST_WR_START: begin
                if (w_xfer_ok) begin
                    w_state_d = ST_POLL;
                    w_write_d = 1'b0;
                    w_read_d  = 1'b1;
                    w_addr_d  = ADDR_W'(c_addr_status);
                    w_wdata_d = 32'd0;
                end
            end
            ST_POLL: begin
                if (!r_read_q) begin
                    w_read_d = 1'b1;
                end else if (w_xfer_ok) begin
                    w_read_d = 1'b0;
                    if (mgmt.mgmt_readdata[0]) begin
                        w_state_d = ST_LOCK_WAIT_REQ;
                        w_addr_d  = '0;
                    end
                end
            end
            ST_LOCK_WAIT_REQ: begin
                if (w_lock_stable) begin
                    w_state_d     = ST_IDLE;
                    w_pll_ready_d = 1'b1;
                    w_done_d      = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_LOCK_WAIT;
            end
        endcase

        if (w_tmo_expired) begin
            w_state_d     = ST_LOCK_WAIT;
            w_write_d     = 1'b0;
            w_read_d      = 1'b0;
            w_addr_d      = '0;
            w_wdata_d     = 32'd0;
            w_done_d      = 1'b0;
            w_error_d     = 1'b1;
            w_pll_ready_d = 1'b0;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state_q     <= ST_LOCK_WAIT;
            r_n_q         <= '0;
            r_m_q         <= '0;
            r_c0_q        <= '0;
            r_addr_q      <= '0;
            r_write_q     <= 1'b0;
            r_read_q      <= 1'b0;
            r_wdata_q     <= '0;
            r_done_q      <= 1'b0;
            r_error_q     <= 1'b0;
            r_pll_ready_q <= 1'b0;
            r_tmo_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_n_q         <= w_n_d;
            r_m_q         <= w_m_d;
            r_c0_q        <= w_c0_d;
            r_addr_q      <= w_addr_d;
            r_write_q     <= w_write_d;
            r_read_q      <= w_read_d;
            r_wdata_q     <= w_wdata_d;
            r_done_q      <= w_done_d;
            r_error_q     <= w_error_d;
            r_pll_ready_q <= w_pll_ready_d;
            r_tmo_q       <= w_tmo_d;
        end
    end

    assign mgmt.mgmt_address   = r_addr_q;
    assign mgmt.mgmt_write     = r_write_q;
    assign mgmt.mgmt_read      = r_read_q;
    assign mgmt.mgmt_writedata = r_wdata_q;

    assign req_ready = (r_state_q == ST_IDLE);
    assign busy      = r_state_q inside {ST_WR_MODE, ST_WR_N, ST_WR_M, ST_WR_C0,
                                         ST_WR_START, ST_POLL, ST_LOCK_WAIT_REQ};
    assign done      = r_done_q;
    assign error     = r_error_q;
    assign pll_ready = r_pll_ready_q;

endmodule
`default_nettype wire

// File: doc/pll_reconfig_sequencer.md
Name: pll_reconfig_sequencer

Overview:
Runtime frequency controller for the lock-in PLL. It takes one counter-set request from the host (N, M, C0 words). It then sequences the Avalon-MM management port of the PLL reconfiguration core: polling mode, counter writes, start, status poll. Finally it waits for a stable PLL lock before reporting completion. Downstream lock-in logic uses pll_ready to hold off while outclk_0 is invalid.

Parameters:
TIMEOUT_CYCLES, 1000000, max refclk cycles allowed from entering WR_START until reconfig done and stable lock
LOCK_STABLE, 1024, consecutive cycles pll_locked must be high before pll_ready asserts
ADDR_W, 6, management address width

Ports:
refclk  in  1  management clock (50 MHz PLL reference)
rst  in  1  synchronous, active-high reset
req_valid  in  1  host request strobe
req_ready  out  1  high only in IDLE
req_n  in  18  N word: [17] odd, [16] bypass, [15:8] hi, [7:0] lo
req_m  in  18  M word, same encoding
req_c0  in  18  C0 word, same encoding
mgmt_address  out  ADDR_W  reconfig register address
mgmt_write  out  1  write strobe
mgmt_read  out  1  read strobe
mgmt_writedata  out  32  write data
mgmt_readdata  in  32  read data, valid when mgmt_read=1 and mgmt_waitrequest=0
mgmt_waitrequest  in  1  slave stall
pll_locked  in  1  PLL locked
pll_ready  out  1  PLL output valid
busy  out  1  sequence in progress
done  out  1  one-cycle pulse, success
error  out  1  sticky timeout flag, cleared by next accepted request

Behaviour:
- Clock and reset: single clock refclk; reset rst is synchronous and active-high.
- Reset values: FSM=LOCK_WAIT, req_ready=0, mgmt_write=0, mgmt_read=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, error=0, pll_ready=0, counters=0. Reset mid-sequence abandons any bus transfer immediately; the PLL must re-lock.
- States: LOCK_WAIT, IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_START, POLL, LOCK_WAIT_REQ.
- LOCK_WAIT (after reset): stable counter increments while pll_locked=1 and clears when it is 0. At LOCK_STABLE, go to IDLE and set pll_ready=1. No timeout in this state.
- IDLE: req_ready=1. When req_valid=1, latch req_n/m/c0, clear error, set busy=1, deassert pll_ready, then go to WR_MODE.
- Write states hold address/data with mgmt_write=1 until a cycle with waitrequest=0. The FSM advances on the next edge. Writes are one transfer each, strictly in order:
  - WR_MODE: addr 0x00, data 1 (polling mode)
  - WR_N: addr 0x03, data {14'b0, n}
  - WR_M: addr 0x04, data {14'b0, m}
  - WR_C0: addr 0x05, data {9'b0, 5'd0, c0}, with counter select at [22:18]
  - WR_START: addr 0x02, data 1; the timeout counter starts here.
- POLL: addr 0x01, mgmt_read=1 until waitrequest=0.
  - readdata[0]=1: go to LOCK_WAIT_REQ.
  - readdata[0]=0: drop read for exactly 1 cycle, then re-issue.
- LOCK_WAIT_REQ: same stable-lock counting as LOCK_WAIT. On reaching LOCK_STABLE: pll_ready=1, done pulses 1 cycle, busy=0, go to IDLE.
- Timeout: counter reaches TIMEOUT_CYCLES in WR_START, POLL or LOCK_WAIT_REQ.
  - Abort: strobes 0, error=1, busy=0, no done pulse.
  - Go to LOCK_WAIT (pll_ready re-asserts only on stable lock).
- Lock loss in IDLE (pll_locked=0): pll_ready=0, go to LOCK_WAIT; req_ready=0 meanwhile.
- Strobe rules: mgmt_write and mgmt_read are never both high. Strobes are registered outputs.
- Widths: stable counter is clog2(LOCK_STABLE+1) bits; timeout counter is clog2(TIMEOUT_CYCLES+1) bits; both saturate.

Decomposition:
- Shared package pll_reconfig_pkg holds:
  - register address constants (MODE=0x00, STATUS=0x01, START=0x02, N=0x03, M=0x04, C=0x05)
  - the FSM state enum
  - a function packing hi/lo/bypass/odd into an 18-bit word
  - the 65 MHz preset constants
- One sub-module, pll_lock_debounce (stable-lock counter with threshold output), reused by LOCK_WAIT and LOCK_WAIT_REQ.

Test Plan:
- Reset, pll_locked=1 from cycle 0, LOCK_STABLE=16 -> pll_ready=1 and req_ready=1 exactly 16 cycles after rst falls.
- Request for 65 MHz (N=0x00101, M=0x20706, C0=0x20302), waitrequest=0 -> write sequence (0x00,1), (0x03,0x00101), (0x04,0x20706), (0x05,0x20302), (0x02,1). Status returns 1 on the 3rd poll. Lock held low for 5 cycles then high -> single done pulse; pll_ready back high after 16 stable cycles.
- waitrequest held high for 7 cycles during WR_M -> address/data stable for 8 cycles; exactly one M write is accepted.
- Status never returns 1, TIMEOUT_CYCLES=200 -> error=1 at cycle 200 after WR_START; no done; strobes low; FSM in LOCK_WAIT.
- pll_locked glitches low for 1 cycle at stable count 10 in LOCK_WAIT_REQ -> count restarts; done delayed accordingly.
- rst asserted mid-POLL -> next cycle all strobes 0, busy=0, error=0; a new request is accepted after re-lock.
